// File: rtl/fetch_queue.sv
// Fetch PC owner and instruction buffer: fetches {inst, pc} pairs from a
// combinational-read memory into a small FIFO so decode can stall independently.
module fetch_queue #(
    parameter int unsigned          DATA_W   = 16,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [DATA_W-1:0]    RESET_PC = '0,
    parameter int unsigned          PC_INC   = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic [DATA_W-1:0]                 imem_addr,
    output logic                              imem_en,
    input  logic [DATA_W-1:0]                 imem_data,
    input  logic                              redirect_valid,
    input  logic [DATA_W-1:0]                 redirect_pc,
    input  logic                              halt,
    input  logic                              inst_ready,
    output logic                              inst_valid,
    output logic [DATA_W-1:0]                 inst_out,
    output logic [DATA_W-1:0]                 inst_pc,
    output logic [DATA_W-1:0]                 inst_pc_next,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic                              err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] inst;
        logic [DATA_W-1:0] pc;
    } entry_t;

    state_e               state_q, state_d;
    logic [DATA_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 err_q, err_d;
    entry_t               entries_q [DEPTH];

    logic                 pop_c;
    logic                 push_c;
    logic                 not_full_c;

    // Handshakes; redirect overrides both, and nothing is fetched while in reset
    assign not_full_c = (count_q < CNT_W'(DEPTH));
    assign pop_c      = inst_valid & inst_ready & ~redirect_valid;
    assign push_c     = rst & (state_q == RUN) & ~halt & ~redirect_valid
                        & (not_full_c | pop_c);

    // Run/halt state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (halt)  state_d = HALTED;
            HALTED:  if (!halt) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Pointer, occupancy, fetch PC and error next-state
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_d      = err_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~DATA_W'(1);
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            err_d      = err_q | redirect_pc[0];
        end else begin
            if (push_c) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + DATA_W'(PC_INC);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push_c) begin
            entries_q[wr_ptr_q] <= '{inst: imem_data, pc: fetch_pc_q};
        end
    end

    assign imem_addr    = fetch_pc_q;
    assign imem_en      = push_c;
    assign inst_valid   = (count_q != '0);
    assign inst_out     = entries_q[rd_ptr_q].inst;
    assign inst_pc      = entries_q[rd_ptr_q].pc;
    assign inst_pc_next = entries_q[rd_ptr_q].pc + DATA_W'(PC_INC);
    assign count        = count_q;
    assign err          = err_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory returns addr ^ 16'hA5A5, expected
// values are hand-derived per step.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic        imem_en;
    logic [15:0] imem_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        inst_ready;
    logic        inst_valid;
    logic [15:0] inst_out;
    logic [15:0] inst_pc;
    logic [15:0] inst_pc_next;
    logic [2:0]  count;
    logic        err;

    int tests = 0;
    int fails = 0;

    fetch_queue #(.DATA_W(16), .DEPTH(4), .RESET_PC(16'h0000), .PC_INC(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_en        (imem_en),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .inst_ready     (inst_ready),
        .inst_valid     (inst_valid),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .inst_pc_next   (inst_pc_next),
        .count          (count),
        .err            (err)
    );

    assign imem_data = imem_addr ^ 16'hA5A5;

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across one edge, then release just after the edge
    task automatic do_reset(input logic ready);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        halt           = 1'b0;
        inst_ready     = ready;
        step();
        rst = 1'b1;
    endtask

    initial begin
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        halt           = 1'b0;
        inst_ready     = 1'b1;
        #1;
        // Reset values
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_imem_en", 32'(imem_en), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'h0000);

        // 1: streaming with decode always ready
        step();
        rst = 1'b1;
        #1;
        chk("t1_first_en", 32'(imem_en), 32'd1);
        chk("t1_first_valid", 32'(inst_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t1_valid", 32'(inst_valid), 32'd1);
            chk("t1_pc", 32'(inst_pc), 32'(16'(2 * k)));
            chk("t1_inst", 32'(inst_out), 32'(16'(2 * k) ^ 16'hA5A5));
            chk("t1_count", 32'(count), 32'd1);
        end

        // 2: backpressure fills the queue, then drain with concurrent refill
        do_reset(1'b0);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("t2_fill_count", 32'(count), (k < 4) ? 32'(k) : 32'd4);
        end
        chk("t2_full_en", 32'(imem_en), 32'd0);
        chk("t2_full_addr", 32'(imem_addr), 32'h0008);
        inst_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("t2_drain_pc", 32'(inst_pc), 32'(16'(2 * k)));
            chk("t2_drain_count", 32'(count), 32'd4);
            step();
        end
        chk("t2_refill_pc", 32'(inst_pc), 32'h0008);

        // 3: redirect with three old entries buffered
        do_reset(1'b0);
        step(); step(); step();
        chk("t3_pre_count", 32'(count), 32'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        inst_ready     = 1'b1;
        #1;
        chk("t3_redir_en", 32'(imem_en), 32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("t3_flush_count", 32'(count), 32'd0);
        chk("t3_flush_valid", 32'(inst_valid), 32'd0);
        chk("t3_new_addr", 32'(imem_addr), 32'h0100);
        step();
        chk("t3_new_pc", 32'(inst_pc), 32'h0100);
        chk("t3_new_inst", 32'(inst_out), 32'h0100 ^ 32'hA5A5);
        chk("t3_new_count", 32'(count), 32'd1);

        // 4: misaligned redirect sets sticky err; async reset clears it
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0203;
        step();
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        #1;
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_addr", 32'(imem_addr), 32'h0202);
        step();
        chk("t4_pc", 32'(inst_pc), 32'h0202);
        step();
        chk("t4_err_sticky", 32'(err), 32'd1);
        chk("t4_pc2", 32'(inst_pc), 32'h0204);
        rst = 1'b0;
        #1;
        chk("t4_async_err", 32'(err), 32'd0);
        chk("t4_async_count", 32'(count), 32'd0);
        chk("t4_async_en", 32'(imem_en), 32'd0);

        // 5: halt drains buffered entries without fetching
        do_reset(1'b0);
        step(); step();
        chk("t5_pre_count", 32'(count), 32'd2);
        halt       = 1'b1;
        inst_ready = 1'b1;
        #1;
        chk("t5_halt_en", 32'(imem_en), 32'd0);
        chk("t5_head0", 32'(inst_pc), 32'h0000);
        step();
        chk("t5_count1", 32'(count), 32'd1);
        chk("t5_head1", 32'(inst_pc), 32'h0002);
        chk("t5_en1", 32'(imem_en), 32'd0);
        step();
        chk("t5_count0", 32'(count), 32'd0);
        chk("t5_en0", 32'(imem_en), 32'd0);
        chk("t5_held_addr", 32'(imem_addr), 32'h0004);
        step();
        chk("t5_no_underflow", 32'(count), 32'd0);
        halt = 1'b0;
        step();
        chk("t5_resume_en", 32'(imem_en), 32'd1);
        chk("t5_resume_addr", 32'(imem_addr), 32'h0004);
        step();
        chk("t5_resume_pc", 32'(inst_pc), 32'h0004);

        // 6: PC wraps at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("t6_addr", 32'(imem_addr), 32'hFFFE);
        chk("t6_err", 32'(err), 32'd0);
        step();
        chk("t6_head", 32'(inst_pc), 32'hFFFE);
        chk("t6_next", 32'(inst_pc_next), 32'h0000);
        chk("t6_wrap_addr", 32'(imem_addr), 32'h0000);
        step();
        chk("t6_head_wrap", 32'(inst_pc), 32'h0000);
        chk("t6_next_wrap", 32'(inst_pc_next), 32'h0002);
        chk("t6_inst_wrap", 32'(inst_out), 32'hA5A5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
